tipi_nibble_link: RTL and testbench

Pi-side transport engine for the TIPI register file. It turns the Raspberry Pi's clocked 4-bit nibble bus into byte-wide register accesses. The Pi can read the TI-written TD/TC latches and write the RD/RC registers that the TI read mux consumes. It sits between the TD/TC latches and the `r_nib` pins of the top level, and owns the nibble framing state machine and an optional parity check.

---
 rtl/tipi_nibble_link.sv | 201 ++++++++++++++++++++
 tb/tb_tipi_nibble_link.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tipi_nibble_link.sv
// tipi_nibble_link: Pi-side nibble transport for the TIPI register file.
// Turns the Pi's clocked 4-bit bus into byte reads of TD/TC/RD/RC and byte
// writes of RD/RC. Frame: CMD -> HI -> LO -> [PAR] -> CMD.
// Build option: define TIPI_NIB_PARITY_EN to add the PAR nibble (driven on
// reads, checked on writes). Undefined, frames are three edges long.
// Bit 0 is the MSB on every vector.
module tipi_nibble_link (
    input  logic       r_clk,
    input  logic       r_nibrst_n,
    input  logic [0:3] r_nib_in,
    output logic [0:3] r_nib_out,
    output logic       r_nib_oe,
    input  logic [0:7] td_in,
    input  logic [0:7] tc_in,
    output logic [0:7] rd_out,
    output logic [0:7] rc_out,
    output logic       rd_wr,
    output logic       rc_wr,
    output logic       busy,
    output logic       xfer_err
);

    typedef enum logic [1:0] {
        StCmd,
        StHi,
        StLo,
        StPar
    } state_e;

    localparam logic [0:1] SelTd = 2'b00;
    localparam logic [0:1] SelTc = 2'b01;
    localparam logic [0:1] SelRd = 2'b10;
    localparam logic [0:1] SelRc = 2'b11;

    // Command that clears the sticky error; all other reserved-bit commands are errors.
    localparam logic [0:3] CmdClrErr = 4'b0100;

    state_e     state_q, state_d;
    logic       dir_q, dir_d;
    logic [0:1] sel_q, sel_d;
    logic [0:7] shadow_q, shadow_d;
    logic [0:3] nib_out_q, nib_out_d;
    logic       oe_q, oe_d;
    logic [0:7] rd_q, rd_d;
    logic [0:7] rc_q, rc_d;
    logic       rd_wr_q, rd_wr_d;
    logic       rc_wr_q, rc_wr_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic [0:7] snap;
    logic       commit;

    // Register selected by the incoming command nibble, for read snapshots.
    always_comb begin
        snap = td_in;
        unique case (r_nib_in[2:3])
            SelTd:   snap = td_in;
            SelTc:   snap = tc_in;
            SelRd:   snap = rd_q;
            SelRc:   snap = rc_q;
            default: snap = td_in;
        endcase
    end

    // Framing FSM: next state, shadow capture, pad drive and commit decode.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        sel_d     = sel_q;
        shadow_d  = shadow_q;
        nib_out_d = nib_out_q;
        oe_d      = oe_q;
        rd_d      = rd_q;
        rc_d      = rc_q;
        rd_wr_d   = 1'b0;
        rc_wr_d   = 1'b0;
        err_d     = err_q;
        commit    = 1'b0;

        unique case (state_q)
            StCmd: begin
                if (r_nib_in[1]) begin
                    // Reserved bit set: only the clear command is legal; stay in CMD.
                    err_d = (r_nib_in == CmdClrErr) ? 1'b0 : 1'b1;
                end else begin
                    dir_d   = r_nib_in[0];
                    sel_d   = r_nib_in[2:3];
                    state_d = StHi;
                    if (r_nib_in[0]) begin
                        // Snapshot now so later TD/TC updates cannot tear the read.
                        shadow_d  = snap;
                        oe_d      = 1'b1;
                        nib_out_d = snap[0:3];
                    end
                end
            end
            StHi: begin
                state_d = StLo;
                if (dir_q) begin
                    nib_out_d = shadow_q[4:7];
                end else begin
                    shadow_d[0:3] = r_nib_in;
                end
            end
            StLo: begin
                if (!dir_q) begin
                    shadow_d[4:7] = r_nib_in;
                end
`ifdef TIPI_NIB_PARITY_EN
                state_d = StPar;
                if (dir_q) begin
                    nib_out_d = shadow_q[0:3] ^ shadow_q[4:7];
                end
`else
                state_d   = StCmd;
                oe_d      = 1'b0;
                nib_out_d = 4'h0;
                commit    = !dir_q;
`endif
            end
            StPar: begin
                state_d   = StCmd;
                oe_d      = 1'b0;
                nib_out_d = 4'h0;
`ifdef TIPI_NIB_PARITY_EN
                if (!dir_q) begin
                    if (r_nib_in == (shadow_q[0:3] ^ shadow_q[4:7])) begin
                        commit = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d   = StCmd;
                oe_d      = 1'b0;
                nib_out_d = 4'h0;
            end
        endcase

        // Final write edge: RD/RC load and strobe; TD/TC are read-only, so flag it.
        if (commit) begin
            unique case (sel_q)
                SelRd: begin
                    rd_d    = shadow_d;
                    rd_wr_d = 1'b1;
                end
                SelRc: begin
                    rc_d    = shadow_d;
                    rc_wr_d = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end

        busy_d = (state_d != StCmd);
    end

    // State and output registers; reset returns everything to idle and clears RD/RC.
    always_ff @(posedge r_clk or negedge r_nibrst_n) begin
        if (!r_nibrst_n) begin
            state_q   <= StCmd;
            dir_q     <= 1'b0;
            sel_q     <= 2'b00;
            shadow_q  <= 8'h00;
            nib_out_q <= 4'h0;
            oe_q      <= 1'b0;
            rd_q      <= 8'h00;
            rc_q      <= 8'h00;
            rd_wr_q   <= 1'b0;
            rc_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            nib_out_q <= nib_out_d;
            oe_q      <= oe_d;
            rd_q      <= rd_d;
            rc_q      <= rc_d;
            rd_wr_q   <= rd_wr_d;
            rc_wr_q   <= rc_wr_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign r_nib_out = nib_out_q;
    assign r_nib_oe  = oe_q;
    assign rd_out    = rd_q;
    assign rc_out    = rc_q;
    assign rd_wr     = rd_wr_q;
    assign rc_wr     = rc_wr_q;
    assign busy      = busy_q;
    assign xfer_err  = err_q;

endmodule

// File: tb/tb_tipi_nibble_link.sv
// Directed bench for tipi_nibble_link; follows TIPI_NIB_PARITY_EN if defined.
module tb_tipi_nibble_link;

    logic       r_clk;
    logic       r_nibrst_n;
    logic [0:3] r_nib_in;
    logic [0:3] r_nib_out;
    logic       r_nib_oe;
    logic [0:7] td_in;
    logic [0:7] tc_in;
    logic [0:7] rd_out;
    logic [0:7] rc_out;
    logic       rd_wr;
    logic       rc_wr;
    logic       busy;
    logic       xfer_err;

    int checks;
    int errors;

    tipi_nibble_link dut (
        .r_clk      (r_clk),
        .r_nibrst_n (r_nibrst_n),
        .r_nib_in   (r_nib_in),
        .r_nib_out  (r_nib_out),
        .r_nib_oe   (r_nib_oe),
        .td_in      (td_in),
        .tc_in      (tc_in),
        .rd_out     (rd_out),
        .rc_out     (rc_out),
        .rd_wr      (rd_wr),
        .rc_wr      (rc_wr),
        .busy       (busy),
        .xfer_err   (xfer_err)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a nibble, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic [0:3] nib);
        r_nib_in = nib;
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        r_nibrst_n = 1'b0;
        r_nib_in   = 4'h0;
        td_in      = 8'hA5;
        tc_in      = 8'h00;
        #12;
        check("rst_oe", r_nib_oe, 0);
        check("rst_out", r_nib_out, 0);
        check("rst_rd", rd_out, 8'h00);
        check("rst_rc", rc_out, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_err", xfer_err, 0);
        check("rst_wr", {rd_wr, rc_wr}, 0);
        r_nibrst_n = 1'b1;

        // Read TD = 0xA5
        step(4'b1000);
        check("rdtd_hi", r_nib_out, 4'hA);
        check("rdtd_hi_oe", r_nib_oe, 1);
        check("rdtd_busy", busy, 1);
        step(4'h0);
        check("rdtd_lo", r_nib_out, 4'h5);
        check("rdtd_lo_oe", r_nib_oe, 1);
`ifdef TIPI_NIB_PARITY_EN
        step(4'h0);
        check("rdtd_par", r_nib_out, 4'hF);
        check("rdtd_par_oe", r_nib_oe, 1);
`endif
        step(4'h0);
        check("rdtd_end_oe", r_nib_oe, 0);
        check("rdtd_end_busy", busy, 0);

        // Write RD = 0x3C
        step(4'b0010);
        check("wrrd_busy", busy, 1);
        check("wrrd_oe", r_nib_oe, 0);
        step(4'h3);
        step(4'hC);
`ifdef TIPI_NIB_PARITY_EN
        check("wrrd_early", rd_wr, 0);
        step(4'hF);
`endif
        check("wrrd_val", rd_out, 8'h3C);
        check("wrrd_stb", rd_wr, 1);
        check("wrrd_rc", rc_out, 8'h00);
        check("wrrd_rcstb", rc_wr, 0);
        check("wrrd_idle", busy, 0);
        step(4'b0100);
        check("wrrd_stb_drop", rd_wr, 0);
        check("wrrd_hold", rd_out, 8'h3C);

`ifdef TIPI_NIB_PARITY_EN
        // Write RC = 0x12 with bad parity 0x0 (correct is 0x3)
        step(4'b0011);
        step(4'h1);
        step(4'h2);
        step(4'h0);
        check("badpar_rc", rc_out, 8'h00);
        check("badpar_stb", rc_wr, 0);
        check("badpar_err", xfer_err, 1);
        check("badpar_idle", busy, 0);
        step(4'b0100);
        check("badpar_clr", xfer_err, 0);
`endif

        // Read TC = 0x81, changed to 0xFF mid-transfer
        tc_in = 8'h81;
        step(4'b1001);
        check("rdtc_hi", r_nib_out, 4'h8);
        tc_in = 8'hFF;
        step(4'h0);
        check("rdtc_lo", r_nib_out, 4'h1);
`ifdef TIPI_NIB_PARITY_EN
        step(4'h0);
        check("rdtc_par", r_nib_out, 4'h9);
`endif
        step(4'h0);
        check("rdtc_end_oe", r_nib_oe, 0);

        // Read back RD (0x3C)
        step(4'b1010);
        check("rdrd_hi", r_nib_out, 4'h3);
        step(4'h0);
        check("rdrd_lo", r_nib_out, 4'hC);
`ifdef TIPI_NIB_PARITY_EN
        step(4'h0);
`endif
        step(4'h0);

        // Abort an RD write of 0x77 after the HI nibble
        step(4'b0010);
        step(4'h7);
        r_nibrst_n = 1'b0;
        #1;
        check("abort_rd", rd_out, 8'h00);
        check("abort_busy", busy, 0);
        @(posedge r_clk);
        #1;
        check("abort_stb", rd_wr, 0);
        r_nibrst_n = 1'b1;
        step(4'b0010);
        step(4'h5);
        step(4'h5);
`ifdef TIPI_NIB_PARITY_EN
        step(4'h0);
`endif
        check("wr55_val", rd_out, 8'h55);
        check("wr55_stb", rd_wr, 1);
        step(4'b0100);
        check("wr55_drop", rd_wr, 0);

        // Write to TD is illegal
        step(4'b0000);
        step(4'h1);
        step(4'h2);
`ifdef TIPI_NIB_PARITY_EN
        check("wrtd_noerr_yet", xfer_err, 0);
        step(4'h3);
`endif
        check("wrtd_err", xfer_err, 1);
        check("wrtd_stb", {rd_wr, rc_wr}, 0);
        check("wrtd_rd", rd_out, 8'h55);
        check("wrtd_rc", rc_out, 8'h00);
        step(4'b0100);
        check("wrtd_clr", xfer_err, 0);

        // Bad reserved command sets the error and does not start a frame
        step(4'b1100);
        check("badcmd_err", xfer_err, 1);
        check("badcmd_busy", busy, 0);
        check("badcmd_oe", r_nib_oe, 0);
        step(4'b0100);
        check("badcmd_clr", xfer_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
